// File: rtl/fft2ram_ctrl_pkg.sv
// Shared definitions for the FFT-to-RAM controller and the FIFO-to-FFT loader.
package fft2ram_ctrl_pkg;

  localparam int unsigned FFT_POINTS_DEF = 1024;
  localparam int unsigned FFT_BUS_DEF    = 10;
  localparam int unsigned DATA_W_DEF     = 16;
  localparam int unsigned MAG_W_DEF      = 32;

  // Cycles spent in DRAIN so the power pipeline empties before publishing.
  localparam int unsigned DRAIN_CYCLES   = 2;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DRAIN,
    PUBLISH
  } state_t;

endpackage

// File: rtl/fft2ram_ctrl_power_pipe.sv
// Two-stage re^2 + im^2 pipeline; valid and {bank, bin} travel alongside the data.
module fft_power_pipe #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned BIN_W  = 10,
  parameter int unsigned MAG_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_bank,
  input  logic [BIN_W-1:0]  in_bin,
  input  logic [DATA_W-1:0] in_real,
  input  logic [DATA_W-1:0] in_imag,
  output logic              out_valid,
  output logic [BIN_W:0]    out_addr,
  output logic [MAG_W-1:0]  out_data
);

  logic signed [2*DATA_W-1:0] re_w;
  logic signed [2*DATA_W-1:0] im_w;
  logic        [2*DATA_W-1:0] sq_re;
  logic        [2*DATA_W-1:0] sq_im;
  logic                       s1_valid;
  logic        [BIN_W:0]      s1_addr;

  // Operands widened first so the signed square is formed at full width.
  assign re_w = {{DATA_W{in_real[DATA_W-1]}}, in_real};
  assign im_w = {{DATA_W{in_imag[DATA_W-1]}}, in_imag};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      sq_re    <= '0;
      sq_im    <= '0;
    end else begin
      s1_valid <= in_valid;
      s1_addr  <= {in_bank, in_bin};
      sq_re    <= re_w * re_w;
      sq_im    <= im_w * im_w;
    end
  end

  // Each square is at most 2^(2*DATA_W-2), so the sum fits 2*DATA_W bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
    end else begin
      out_valid <= s1_valid;
      out_addr  <= s1_addr;
      out_data  <= MAG_W'(sq_re + sq_im);
    end
  end

endmodule

// File: rtl/fft2ram_ctrl.sv
// Writes FFT bin power into the inactive RAM bank and publishes completed frames to the Nios.
module fft2ram_ctrl
  import fft2ram_ctrl_pkg::*;
#(
  parameter int unsigned FFT_POINTS = FFT_POINTS_DEF,
  parameter int unsigned FFT_BUS    = FFT_BUS_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned MAG_W      = MAG_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              source_valid,
  input  logic              source_sop,
  input  logic              source_eop,
  input  logic [1:0]        source_error,
  input  logic [DATA_W-1:0] source_real,
  input  logic [DATA_W-1:0] source_imag,
  output logic              source_ready,
  output logic [FFT_BUS:0]  ram_wraddr,
  output logic [MAG_W-1:0]  ram_wrdata,
  output logic              ram_wren,
  output logic              rd_bank,
  output logic              frame_ready,
  input  logic              nios_ack,
  output logic              frame_drop,
  output logic              frame_err
);

  localparam logic [FFT_BUS-1:0] LAST_BIN  = FFT_BUS'(FFT_POINTS - 1);
  localparam logic [1:0]         DRAIN_END = 2'(DRAIN_CYCLES - 1);

  state_t              state, state_next;
  logic [FFT_BUS-1:0]  bin, bin_next, bin_inc, wr_bin;
  logic                bad, bad_next;
  logic [1:0]          dcnt, dcnt_next;
  logic                wr_bank;
  logic                accept, beat_err, wr_en, err_set, publish, held_ready;

  assign accept     = source_valid & source_ready;
  assign beat_err   = |source_error;
  assign bin_inc    = bin + 1'b1;
  assign held_ready = frame_ready & ~nios_ack;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      bin   <= '0;
      bad   <= 1'b0;
      dcnt  <= '0;
    end else begin
      state <= state_next;
      bin   <= bin_next;
      bad   <= bad_next;
      dcnt  <= dcnt_next;
    end
  end

  always_comb begin
    state_next = state;
    bin_next   = bin;
    bad_next   = bad;
    dcnt_next  = '0;
    wr_en      = 1'b0;
    wr_bin     = '0;
    err_set    = 1'b0;
    publish    = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept && source_sop) begin
          state_next = CAPTURE;
          bin_next   = '0;
          bad_next   = beat_err;
          wr_en      = 1'b1;
        end
      end
      CAPTURE: begin
        if (accept) begin
          if (source_sop) begin
            // Restart in the same bank; the aborted frame is reported.
            err_set  = 1'b1;
            bin_next = '0;
            bad_next = beat_err;
            wr_en    = 1'b1;
          end else if (bin == LAST_BIN) begin
            err_set    = 1'b1;
            state_next = IDLE;
          end else begin
            bin_next = bin_inc;
            bad_next = bad | beat_err;
            wr_en    = 1'b1;
            wr_bin   = bin_inc;
            if (source_eop) begin
              if (bin_inc == LAST_BIN && !(bad || beat_err)) begin
                state_next = DRAIN;
              end else begin
                err_set    = 1'b1;
                state_next = IDLE;
              end
            end
          end
        end
      end
      DRAIN: begin
        dcnt_next = dcnt + 1'b1;
        if (dcnt == DRAIN_END) begin
          dcnt_next  = '0;
          state_next = PUBLISH;
        end
      end
      PUBLISH: begin
        publish    = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

  // The ack is folded in before the publish decision, so a same-cycle ack frees the slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      source_ready <= 1'b0;
      wr_bank      <= 1'b0;
      rd_bank      <= 1'b1;
      frame_ready  <= 1'b0;
      frame_drop   <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      source_ready <= 1'b1;
      frame_err    <= err_set;
      frame_drop   <= publish & held_ready;
      if (publish && !held_ready) begin
        rd_bank     <= wr_bank;
        wr_bank     <= ~wr_bank;
        frame_ready <= 1'b1;
      end else begin
        frame_ready <= held_ready;
      end
    end
  end

  fft_power_pipe #(
    .DATA_W (DATA_W),
    .BIN_W  (FFT_BUS),
    .MAG_W  (MAG_W)
  ) u_power_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (wr_en),
    .in_bank   (wr_bank),
    .in_bin    (wr_bin),
    .in_real   (source_real),
    .in_imag   (source_imag),
    .out_valid (ram_wren),
    .out_addr  (ram_wraddr),
    .out_data  (ram_wrdata)
  );

endmodule

// File: tb/tb_fft2ram_ctrl.sv
// Directed bench for fft2ram_ctrl with 8-bin frames and a write scoreboard.
module tb_fft2ram_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        source_valid = 1'b0;
  logic        source_sop = 1'b0;
  logic        source_eop = 1'b0;
  logic [1:0]  source_error = 2'b00;
  logic [15:0] source_real = '0;
  logic [15:0] source_imag = '0;
  logic        source_ready;
  logic [3:0]  ram_wraddr;
  logic [31:0] ram_wrdata;
  logic        ram_wren;
  logic        rd_bank;
  logic        frame_ready;
  logic        nios_ack = 1'b0;
  logic        frame_drop;
  logic        frame_err;

  int checks = 0;
  int errors = 0;
  int drop_cnt = 0;
  int err_cnt = 0;
  logic [35:0] sb[$];

  always #50 clk = ~clk;

  fft2ram_ctrl #(
    .FFT_POINTS (8),
    .FFT_BUS    (3),
    .DATA_W     (16),
    .MAG_W      (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .source_valid (source_valid),
    .source_sop   (source_sop),
    .source_eop   (source_eop),
    .source_error (source_error),
    .source_real  (source_real),
    .source_imag  (source_imag),
    .source_ready (source_ready),
    .ram_wraddr   (ram_wraddr),
    .ram_wrdata   (ram_wrdata),
    .ram_wren     (ram_wren),
    .rd_bank      (rd_bank),
    .frame_ready  (frame_ready),
    .nios_ack     (nios_ack),
    .frame_drop   (frame_drop),
    .frame_err    (frame_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (frame_drop) drop_cnt++;
      if (frame_err) err_cnt++;
      if (ram_wren) begin
        logic [35:0] e;
        chk("write_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("wr_addr", ram_wraddr, e[35:32]);
          chk("wr_data", ram_wrdata, e[31:0]);
        end
      end
    end
  end

  task automatic beat(input logic sop, input logic eop, input logic [1:0] err,
                      input int re, input int im, input logic wr, input logic [3:0] addr);
    longint p;
    @(negedge clk);
    source_valid = 1'b1;
    source_sop   = sop;
    source_eop   = eop;
    source_error = err;
    source_real  = 16'(re);
    source_imag  = 16'(im);
    if (wr) begin
      p = longint'(re) * re + longint'(im) * im;
      sb.push_back({addr, p[31:0]});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      source_valid = 1'b0;
      source_sop   = 1'b0;
      source_eop   = 1'b0;
      source_error = 2'b00;
    end
  endtask

  task automatic frame(input logic bank, input int off);
    for (int k = 0; k < 8; k++)
      beat(k == 0, k == 7, 2'b00, k + off, -(k + off), 1'b1, {bank, 3'(k)});
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    source_valid = 1'b0;
    nios_ack = 1'b1;
    @(negedge clk);
    nios_ack = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", source_ready, 1'b0);
    chk("rst_wren", ram_wren, 1'b0);
    chk("rst_addr", ram_wraddr, 4'h0);
    chk("rst_data", ram_wrdata, 32'h0);
    chk("rst_rd_bank", rd_bank, 1'b1);
    chk("rst_frame_ready", frame_ready, 1'b0);
    chk("rst_drop", frame_drop, 1'b0);
    chk("rst_err", frame_err, 1'b0);
    reset = 1'b0;
    #1 chk("ready_after_release", source_ready, 1'b0);
    @(negedge clk);
    chk("ready_rise", source_ready, 1'b1);

    // Clean frame into bank 0 with exact drain/publish timing.
    frame(1'b0, 0);
    idle(2);
    chk("last_bin_wren", ram_wren, 1'b1);
    chk("last_bin_addr", ram_wraddr, 4'h7);
    idle(1);
    chk("drain_no_wren", ram_wren, 1'b0);
    chk("drain_not_ready", frame_ready, 1'b0);
    idle(1);
    chk("pub1_ready", frame_ready, 1'b1);
    chk("pub1_rd_bank", rd_bank, 1'b0);

    // Extremes in a second frame, which must be dropped (no ack yet).
    beat(1'b1, 1'b0, 2'b00, -32768, -32768, 1'b1, 4'h8);
    beat(1'b0, 1'b0, 2'b00, 32767, 0, 1'b1, 4'h9);
    for (int k = 2; k < 8; k++)
      beat(1'b0, k == 7, 2'b00, 3 * k, k, 1'b1, {1'b1, 3'(k)});
    idle(6);
    chk("drop_count", drop_cnt, 1);
    chk("drop_rd_bank", rd_bank, 1'b0);
    chk("drop_ready", frame_ready, 1'b1);

    ack_pulse();
    chk("ack_clears", frame_ready, 1'b0);
    frame(1'b1, 3);
    idle(6);
    chk("pub3_ready", frame_ready, 1'b1);
    chk("pub3_rd_bank", rd_bank, 1'b1);
    ack_pulse();
    chk("ack2_clears", frame_ready, 1'b0);
    ack_pulse();
    chk("stray_ack_ready", frame_ready, 1'b0);
    chk("stray_ack_rd_bank", rd_bank, 1'b1);

    // Short frame: eop at bin 5.
    for (int k = 0; k < 6; k++)
      beat(k == 0, k == 5, 2'b00, k + 1, k, 1'b1, {1'b0, 3'(k)});
    idle(6);
    chk("short_err", err_cnt, 1);
    chk("short_no_pub", frame_ready, 1'b0);

    // Error code on bin 3.
    for (int k = 0; k < 8; k++)
      beat(k == 0, k == 7, (k == 3) ? 2'b01 : 2'b00, k, 2 * k, 1'b1, {1'b0, 3'(k)});
    idle(6);
    chk("errcode_err", err_cnt, 2);
    chk("errcode_no_pub", frame_ready, 1'b0);
    chk("errcode_rd_bank", rd_bank, 1'b1);

    // sop at bin 4 restarts the frame in bank 0.
    for (int k = 0; k < 4; k++)
      beat(k == 0, 1'b0, 2'b00, k, k, 1'b1, {1'b0, 3'(k)});
    frame(1'b0, 10);
    idle(6);
    chk("restart_err", err_cnt, 3);
    chk("restart_pub", frame_ready, 1'b1);
    chk("restart_rd_bank", rd_bank, 1'b0);

    // Beat without sop in IDLE is ignored; then a frame overrunning bin 7.
    beat(1'b0, 1'b0, 2'b00, 5, 5, 1'b0, 4'h0);
    idle(3);
    for (int k = 0; k < 8; k++)
      beat(k == 0, 1'b0, 2'b00, k, -k, 1'b1, {1'b1, 3'(k)});
    beat(1'b0, 1'b0, 2'b00, 9, 9, 1'b0, 4'h0);
    idle(6);
    chk("overrun_err", err_cnt, 4);
    chk("overrun_rd_bank", rd_bank, 1'b0);
    chk("overrun_ready", frame_ready, 1'b1);

    // Ack arriving in the PUBLISH cycle.
    frame(1'b1, 20);
    idle(3);
    nios_ack = 1'b1;
    idle(1);
    nios_ack = 1'b0;
    chk("simul_ready", frame_ready, 1'b1);
    chk("simul_rd_bank", rd_bank, 1'b1);
    chk("simul_no_drop", drop_cnt, 1);
    ack_pulse();

    // Reset in the middle of a frame.
    for (int k = 0; k < 5; k++)
      beat(k == 0, 1'b0, 2'b00, k, k, 1'b1, {1'b0, 3'(k)});
    @(negedge clk);
    #2 reset = 1'b1;
    source_valid = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_ready", source_ready, 1'b0);
    chk("mid_rst_wren", ram_wren, 1'b0);
    chk("mid_rst_addr", ram_wraddr, 4'h0);
    chk("mid_rst_data", ram_wrdata, 32'h0);
    chk("mid_rst_rd_bank", rd_bank, 1'b1);
    chk("mid_rst_frame_ready", frame_ready, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", source_ready, 1'b1);
    frame(1'b0, 7);
    idle(6);
    chk("post_rst_pub", frame_ready, 1'b1);
    chk("post_rst_rd_bank", rd_bank, 1'b0);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft2ram_ctrl.md
Name: fft2ram_ctrl

Overview:
Sequences the FFT output stream into a double-buffered dual-port RAM that the Nios reads. Squares and sums each complex bin into a power value, writes bins to the inactive bank, and publishes a completed frame to the Nios with a ready/ack handshake. Sits downstream of the FFT core and alongside the FIFO-to-FFT loader, closing the audio -> FFT -> Nios path.

Parameters:
FFT_POINTS, 1024, number of bins per frame; power of two
FFT_BUS, 10, log2(FFT_POINTS); bin address width
DATA_W, 16, width of FFT real/imag outputs (signed)
MAG_W, 32, width of power word written to RAM; must be >= 2*DATA_W

Ports:
clk  in  1  10 MHz system clock
reset  in  1  asynchronous, active-high
source_valid  in  1  FFT output beat valid
source_sop  in  1  first bin of FFT frame
source_eop  in  1  last bin of FFT frame
source_error  in  2  FFT error code; nonzero marks the frame bad
source_real  in  DATA_W  signed real part
source_imag  in  DATA_W  signed imaginary part
source_ready  out  1  controller accepts FFT output
ram_wraddr  out  FFT_BUS+1  {bank, bin index}
ram_wrdata  out  MAG_W  power value re^2+im^2, zero-extended
ram_wren  out  1  RAM write strobe
rd_bank  out  1  bank the Nios must read
frame_ready  out  1  a published frame is waiting for the Nios
nios_ack  in  1  one-cycle pulse: Nios has finished reading rd_bank
frame_drop  out  1  one-cycle pulse: good frame discarded because Nios has not acked
frame_err  out  1  one-cycle pulse: malformed or errored frame discarded

Behaviour:
- Reset values: source_ready=0, ram_wren=0, ram_wraddr=0, ram_wrdata=0, rd_bank=1, frame_ready=0, frame_drop=0, frame_err=0. Internal write bank=0. source_ready rises one cycle after reset deasserts and then stays 1.
- Beat accept: source_valid & source_ready.
- Power pipeline: 2 stages. Stage 1 registers re*re and im*im, both signed DATA_W x DATA_W. Stage 2 registers the unsigned sum. ram_wren/ram_wraddr/ram_wrdata appear 2 cycles after the accepted beat. The sum is at most 2^(2*DATA_W-1), so it fits 2*DATA_W bits unsigned. The result is zero-extended to MAG_W.
- States:
  - IDLE: wait for an accepted beat with sop. Go to CAPTURE with bin=0, which is written. Beats without sop are ignored and not written.
  - CAPTURE: each accepted beat increments bin. Writes go to {wr_bank, bin}.
    - eop with bin==FFT_POINTS-1 and no error seen -> DRAIN.
    - eop with any other bin -> frame_err, go to IDLE.
    - bin would exceed FFT_POINTS-1 without eop -> frame_err, go to IDLE.
    - sop mid-frame -> frame_err, then restart the frame at bin 0 in the same bank.
    - Any accepted beat with source_error != 0 latches a bad flag. eop then gives frame_err instead of DRAIN.
  - DRAIN: hold 2 cycles for the pipeline to empty, then go to PUBLISH.
  - PUBLISH: 1 cycle.
    - If frame_ready==0: rd_bank<=wr_bank, wr_bank<=~wr_bank, frame_ready<=1.
    - Else: frame_drop pulse, banks unchanged, so the next frame overwrites the same write bank.
    - Always return to IDLE.
- nios_ack clears frame_ready the next cycle. An ack with frame_ready==0 is ignored.
- If nios_ack and PUBLISH occur in the same cycle, the ack is processed first. The frame publishes (no drop), and frame_ready stays 1 with rd_bank swapped.
- The discarded-frame bank is never exposed; rd_bank changes only in PUBLISH.
- Reset mid-frame: everything returns to reset values. Any partial bank contents are abandoned.

Decomposition:
- Shared package: state encoding constants (IDLE, CAPTURE, DRAIN, PUBLISH), FFT_POINTS/FFT_BUS/DATA_W defaults shared with the FIFO-to-FFT loader, and the DRAIN length constant (2).
- One sub-module: fft_power_pipe. It holds the 2-stage re^2+im^2 pipeline and carries valid, address and bank alongside the data.

Test Plan:
- Clean frame, FFT_POINTS=8: bin k with re=k, im=-k -> RAM {0,k} gets 2k^2; bin 7 is written 2 cycles after eop; frame_ready=1 and rd_bank=0 one cycle after DRAIN.
- Extremes, DATA_W=16: re=im=-32768 -> ram_wrdata=0x8000_0000; re=32767, im=0 -> 0x3FFF_0001.
- Back-to-back frames without nios_ack: second frame -> frame_drop pulse, rd_bank stays 0, frame_ready stays 1. Ack, then a third frame -> rd_bank=1.
- Error paths: eop at bin 5 of 8 -> frame_err, no publish. source_error=2'b01 on bin 3 -> frame_err at eop. sop at bin 4 -> frame_err, then a full 8-bin frame publishes normally.
- Simultaneous nios_ack and PUBLISH -> no frame_drop, frame_ready remains 1, rd_bank toggles.
- Assert reset at bin 4 -> all outputs at reset values within the cycle. A following clean frame publishes to bank 0.
